// File: rtl/dot_arbiter_if.sv
// Requester-side bundle of dot_arbiter: request/accept handshake, one-hot
// response valid/ready and the shared result bus.
interface dot_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_ready;
    logic [N_REQ-1:0] rsp_valid;
    logic [N_REQ-1:0] rsp_ready;
    logic [15:0]      rsp_data;
    logic             rsp_err;

    modport master (
        output req_valid, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/dot_arbiter.sv
// Round-robin arbiter sharing one dot-product engine among N_REQ requesters,
// with a WAIT timeout that returns an error response instead of a result.
//
// state | meaning
// IDLE  | no operation; pick a winner when any request is pending
// START | one cycle: accept pulse to winner, engine start pulse
// WAIT  | waiting for eng_done or for the timeout counter to expire
// RESP  | result (or error) held to the winner until its rsp_ready
module dot_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    dot_arbiter_if.slave             bus,
    output logic                     eng_start,
    output logic [$clog2(N_REQ)-1:0] eng_sel,
    input  logic                     eng_done,
    input  logic [15:0]              eng_result,
    output logic                     busy,
    output logic [15:0]              op_count
);
    localparam int SW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    ptr_q, ptr_d, sel_q, sel_d, win, off;
    logic [SW:0]      sum;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0] rot, win_hot, sel_hot;
    logic [N_REQ-1:0] req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
    logic [15:0]      rsp_data_q, rsp_data_d, op_count_q, op_count_d;
    logic             rsp_err_q, rsp_err_d, eng_start_q, eng_start_d;
    logic             busy_q, busy_d, found;

    // Rotate requests so bit 0 is the requester at ptr; the lowest set bit wins.
    always_comb begin
        rot   = N_REQ'({bus.req_valid, bus.req_valid} >> ptr_q);
        found = |rot;
        off   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = SW'(i);
        end
        sum = {1'b0, ptr_q} + {1'b0, off};
        win = (sum >= (SW+1)'(N_REQ)) ? SW'(sum - (SW+1)'(N_REQ)) : sum[SW-1:0];
    end

    assign win_hot = N_REQ'(1) << win;
    assign sel_hot = N_REQ'(1) << sel_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        req_ready_d = '0;
        eng_start_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        op_count_d  = op_count_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = START;
                    sel_d       = win;
                    ptr_d       = (win == SW'(N_REQ - 1)) ? '0 : win + 1'b1;
                    req_ready_d = win_hot;
                    eng_start_d = 1'b1;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // done is checked first so it wins over a coinciding timeout
                if (eng_done) begin
                    rsp_data_d  = eng_result;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = sel_hot;
                    state_d     = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = sel_hot;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (|(bus.rsp_ready & sel_hot)) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                    if (!rsp_err_q) op_count_d = op_count_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            eng_start_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            op_count_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            eng_start_q <= eng_start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            op_count_q  <= op_count_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign eng_start     = eng_start_q;
    assign eng_sel       = sel_q;
    assign busy          = busy_q;
    assign op_count      = op_count_q;
endmodule

// File: tb/tb_dot_arbiter.sv
// Scoreboard bench for dot_arbiter: the stimulus side models requesters and the
// engine and queues expected responses; a monitor checks them as they appear.
module tb_dot_arbiter;
    localparam int N  = 4;
    localparam int T  = 8;
    localparam int SW = $clog2(N);

    typedef struct {
        int          idx;
        logic [15:0] data;
        logic        err;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          eng_start, eng_done, busy;
    logic [SW-1:0] eng_sel;
    logic [15:0]   eng_result, op_count;

    dot_arbiter_if #(.N_REQ(N)) bus ();

    dot_arbiter #(.N_REQ(N), .TIMEOUT(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .eng_start  (eng_start),
        .eng_sel    (eng_sel),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    rsp_t        exp_q[$];
    int          grant_log[$];
    int          m_ptr = 0;
    logic [15:0] exp_ops = '0;
    int          cyc = 0, start_cyc = 0, rsp_cyc = 0, start_cnt = 0;
    bit          rv_seen = 0;
    int          eng_cnt = -1;
    logic [15:0] eng_data = '0;
    // stimulus knobs
    bit          rnd_req = 0, hold_req = 0;
    int          rdy_mode = 1;
    logic [N-1:0] rdy_fix = '0;
    int          eng_mode = 0;
    int          fix_delay = 1;
    logic [15:0] fix_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: first pending requester at or after m_ptr, wrapping.
    function automatic int model_pick();
        int j;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (bus.req_valid[j]) return j;
        end
        return -1;
    endfunction

    task automatic tick();
        int          w;
        int          d;
        logic [15:0] data;
        @(negedge clk);
        cyc++;
        eng_done   = 1'b0;
        eng_result = 16'($urandom);
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_done   = 1'b1;
                eng_result = eng_data;
            end
        end
        if (eng_start) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (bus.req_ready != '0 || eng_start) begin
            w = model_pick();
            check("grant_onehot", 32'(bus.req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
            check("grant_start", 32'(eng_start), 32'd1);
            check("grant_sel", 32'(eng_sel), 32'(w));
            if (w >= 0) begin
                m_ptr = (w + 1) % N;
                grant_log.push_back(w);
                d = (eng_mode == 1) ? fix_delay : (eng_mode == 2) ? 0 :
                    (($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, T)));
                data = (eng_mode == 1) ? fix_data : 16'($urandom);
                if (d == 0) begin
                    eng_cnt = -1;
                    exp_q.push_back('{w, 16'h0000, 1'b1});
                end else begin
                    eng_cnt  = d;
                    eng_data = data;
                    exp_q.push_back('{w, data, 1'b0});
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (bus.req_ready[i]) begin
                if (!hold_req && (!rnd_req || $urandom_range(0, 1) == 0)) bus.req_valid[i] = 1'b0;
            end else if (rnd_req && !bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
                bus.req_valid[i] = 1'b1;
            end
        end
        case (rdy_mode)
            0:       bus.rsp_ready = N'($urandom);
            1:       bus.rsp_ready = '1;
            default: bus.rsp_ready = rdy_fix;
        endcase
        if (bus.rsp_valid != '0 && !rv_seen) begin
            rv_seen = 1;
            rsp_cyc = cyc;
        end
        if (bus.rsp_valid == '0) rv_seen = 0;
    endtask

    task automatic run_until_idle(input int budget, input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((bus.req_valid != '0 || busy || exp_q.size() != 0) && n < budget);
        check({name, "_complete"}, 32'(n < budget), 32'd1);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n         = 1'b0;
        bus.req_valid = '0;
        eng_cnt       = -1;
        eng_done      = 1'b0;
        repeat (cycles) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_eng_start", 32'(eng_start), 32'd0);
        check("rst_eng_sel", 32'(eng_sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        exp_q.delete();
        m_ptr   = 0;
        exp_ops = '0;
        rst_n   = 1'b1;
    endtask

    // Response monitor: pops on each new response, then checks it stays put.
    bit          in_rsp = 0;
    logic [N-1:0] held_v;
    logic [15:0] held_d;
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_rsp = 0;
            end else if (bus.rsp_valid != '0) begin
                if (!in_rsp) begin
                    in_rsp = 1;
                    held_v = bus.rsp_valid;
                    held_d = bus.rsp_data;
                    check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        r = exp_q.pop_front();
                        check("rsp_valid", 32'(bus.rsp_valid), 32'd1 << r.idx);
                        check("rsp_data", 32'(bus.rsp_data), 32'(r.data));
                        check("rsp_err", 32'(bus.rsp_err), 32'(r.err));
                        check("rsp_sel", 32'(eng_sel), 32'(r.idx));
                        if (!r.err) exp_ops++;
                    end
                    check("rsp_busy", 32'(busy), 32'd1);
                end else begin
                    check("hold_valid", 32'(bus.rsp_valid), 32'(held_v));
                    check("hold_data", 32'(bus.rsp_data), 32'(held_d));
                end
            end else if (in_rsp) begin
                in_rsp = 0;
                check("op_count", 32'(op_count), 32'(exp_ops));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    initial begin
        int          n;
        int          s0;
        logic [15:0] ops_before;
        int          cont_exp[5] = '{0, 1, 2, 3, 0};
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        eng_done      = 1'b0;
        eng_result    = '0;
        do_reset(3);

        // single request, done 5 cycles after start
        grant_log.delete();
        rdy_mode = 1; eng_mode = 1; fix_delay = 5; fix_data = 16'h1234;
        bus.req_valid = 4'b0001;
        run_until_idle(100, "single");
        check("single_grants", 32'(grant_log.size()), 32'd1);
        if (grant_log.size() > 0) check("single_idx", 32'(grant_log[0]), 32'd0);
        check("single_op_count", 32'(op_count), 32'd1);

        // contention with all requests held
        do_reset(2);
        grant_log.delete();
        eng_mode = 0; hold_req = 1; s0 = start_cnt;
        bus.req_valid = '1;
        n = 0;
        while (grant_log.size() < 5 && n < 400) begin
            tick();
            n++;
        end
        bus.req_valid = '0;
        hold_req = 0;
        check("cont_budget", 32'(n < 400), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k < grant_log.size()) check("cont_order", 32'(grant_log[k]), 32'(cont_exp[k]));
        end
        run_until_idle(200, "cont");
        check("cont_starts", 32'(start_cnt - s0), 32'd5);

        // timeout
        eng_mode = 2; ops_before = exp_ops;
        bus.req_valid = 4'b0010;
        run_until_idle(100, "timeout");
        check("timeout_latency", 32'(rsp_cyc - start_cyc), 32'(T + 1));
        check("timeout_op_count", 32'(op_count), 32'(ops_before));

        // backpressure, other rsp_ready bits high
        eng_mode = 1; fix_delay = 3; fix_data = 16'hBEEF;
        rdy_mode = 2; rdy_fix = 4'b1110;
        bus.req_valid = 4'b0001;
        n = 0;
        while (bus.rsp_valid == '0 && n < 50) begin
            tick();
            n++;
        end
        check("bp_reach", 32'(n < 50), 32'd1);
        s0 = start_cnt;
        bus.req_valid[2] = 1'b1;
        repeat (10) tick();
        check("bp_valid", 32'(bus.rsp_valid), 32'b0001);
        check("bp_data", 32'(bus.rsp_data), 32'hBEEF);
        check("bp_no_start", 32'(start_cnt), 32'(s0));
        check("bp_busy", 32'(busy), 32'd1);
        rdy_mode = 1;
        run_until_idle(100, "bp");

        // reset while in WAIT
        eng_mode = 2;
        bus.req_valid = 4'b1000;
        n = 0;
        while (!eng_start && n < 50) begin
            tick();
            n++;
        end
        tick();
        tick();
        check("rw_busy", 32'(busy), 32'd1);
        do_reset(2);
        grant_log.delete();
        eng_mode = 1; fix_delay = 2; fix_data = 16'h5A5A;
        bus.req_valid = 4'b0100;
        run_until_idle(100, "rw");
        if (grant_log.size() > 0) check("rw_idx", 32'(grant_log[0]), 32'd2);
        do_reset(2);
        grant_log.delete();
        bus.req_valid = 4'b1001;
        run_until_idle(100, "rw_ptr");
        if (grant_log.size() > 0) check("rw_ptr_idx", 32'(grant_log[0]), 32'd0);

        // op_count wrap
        tick();
        force dut.op_count_q = 16'hFFFF;
        tick();
        release dut.op_count_q;
        exp_ops = 16'hFFFF;
        check("wrap_preload", 32'(op_count), 32'hFFFF);
        bus.req_valid = 4'b0010;
        run_until_idle(100, "wrap");
        check("wrap_op_count", 32'(op_count), 32'd0);

        // randomized traffic
        rnd_req = 1; rdy_mode = 0; eng_mode = 0;
        repeat (800) tick();
        rnd_req = 0; rdy_mode = 1;
        run_until_idle(600, "rand");
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        check("rand_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
